// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receiver: FSM state encoding and the
// LRCLK level that selects the left channel.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_e;

    localparam logic I2S_LEFT = 1'b0;

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop synchronisers for BCLK/LRCLK/SDATA plus BCLK rising-edge detect.
// All three outputs come from the same stage, so they line up on the same clk.
module i2s_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic bclk,
    input  logic lrclk,
    input  logic sdata,
    output logic bclk_rise,
    output logic lr_s,
    output logic sd_s
);

    // {bclk, lrclk, sdata} through two metastability stages
    logic [2:0] sync_p0_q, sync_p0_d;
    logic [2:0] sync_p1_q, sync_p1_d;
    logic       bclk_p2_q, bclk_p2_d;

    always_comb begin
        sync_p0_d = {bclk, lrclk, sdata};
        sync_p1_d = sync_p0_q;
        bclk_p2_d = sync_p1_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0_q <= '0;
            sync_p1_q <= '0;
            bclk_p2_q <= 1'b0;
        end else begin
            sync_p0_q <= sync_p0_d;
            sync_p1_q <= sync_p1_d;
            bclk_p2_q <= bclk_p2_d;
        end
    end

    assign bclk_rise = sync_p1_q[2] & ~bclk_p2_q;
    assign lr_s      = sync_p1_q[1];
    assign sd_s      = sync_p1_q[0];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: frames the oversampled BCLK/LRCLK/SDATA stream and
// delivers one left/right pair per frame with a single-cycle valid strobe.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = 12,
    parameter int SLOT_MAX = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                BCLK,
    input  logic                LRCLK,
    input  logic                SDATA,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic                valid,
    output logic                locked
);

    localparam int IDX_W = $clog2(SLOT_MAX + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int POS_W = $clog2(SAMPLE_W);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(SLOT_MAX);
    localparam logic [IDX_W-1:0] IDX_KEEP = IDX_W'(SAMPLE_W);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(SAMPLE_W - 1);

    function automatic logic [IDX_W-1:0] idx_sat_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_MAX) ? v : v + IDX_W'(1);
    endfunction

    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] v);
        return (v == TO_MAX) ? v : v + TO_W'(1);
    endfunction

    logic bclk_rise, lr_s, sd_s;

    i2s_pin_sync u_pin_sync (
        .clk       (clk),
        .rst       (rst),
        .bclk      (BCLK),
        .lrclk     (LRCLK),
        .sdata     (SDATA),
        .bclk_rise (bclk_rise),
        .lr_s      (lr_s),
        .sd_s      (sd_s)
    );

    i2s_state_e          state_q, state_d;
    logic                lr_prev_q, lr_prev_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                valid_q, valid_d;

    logic                edge_tr;
    logic                timeout;
    logic [POS_W-1:0]    pos;
    logic [SAMPLE_W-1:0] shifted;

    // The first rise after an LRCLK change still carries the old channel's LSB
    assign edge_tr = bclk_rise && (lr_s != lr_prev_q);
    assign timeout = (to_q == TO_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:  if (edge_tr && lr_s == I2S_LEFT) state_d = ST_LEFT;
                ST_LEFT:  if (timeout) state_d = ST_SYNC;
                          else if (edge_tr) state_d = ST_RIGHT;
                ST_RIGHT: if (timeout) state_d = ST_SYNC;
                          else if (edge_tr) state_d = ST_LEFT;
                default:  state_d = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        pos     = POS_TOP - POS_W'(idx_q);
        shifted = shift_q;
        if (idx_q < IDX_KEEP) shifted[pos] = sd_s;

        lr_prev_d   = bclk_rise ? lr_s : lr_prev_q;
        to_d        = bclk_rise ? '0 : to_sat_inc(to_q);
        idx_d       = idx_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;

        // Timeout beats a coincident transition edge; partial frame is dropped
        if (!en || state_q == ST_SYNC || timeout) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (bclk_rise) begin
            if (edge_tr) begin
                idx_d   = '0;
                shift_d = '0;
                if (state_q == ST_LEFT) begin
                    left_hold_d = shifted;
                end else begin
                    left_d  = left_hold_q;
                    right_d = shifted;
                    valid_d = 1'b1;
                end
            end else begin
                idx_d   = idx_sat_inc(idx_q);
                shift_d = shifted;
            end
        end

        locked = (state_q != ST_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev_q   <= 1'b0;
            idx_q       <= '0;
            to_q        <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            lr_prev_q   <= lr_prev_d;
            idx_q       <= idx_d;
            to_q        <= to_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign valid = valid_q;

endmodule
